dac_out_ctrl: RTL
=================

DAC_OUT_CTRL -- requirements
Module: dac_out_ctrl

Interface
REQ-001 SHALL have parameter BIT_DAC, default 14: width of the sample and DAC code.
REQ-002 SHALL have parameter RAMP_BITS, default 4: log2 of the ramp length in clocks.
REQ-003 SHALL have port clock_5000, input, 1 bit: sample clock; all registers update on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1 bit: request to transmit (level).
REQ-006 SHALL have port in_sample, input, BIT_DAC bits: signed two's-complement IF sample from the 16-QAM shaping filter, one per clock.
REQ-007 SHALL have port gain_shift, input, 2 bits: left-shift gain of 0..3.
REQ-008 SHALL have port dac_data, output, BIT_DAC bits: registered DAC code.
REQ-009 SHALL have port dac_valid, output, 1 bit: dac_data carries ramped or running signal.
REQ-010 SHALL have port state, output, 2 bits: current FSM state.
REQ-011 SHALL have port sat_count, output, 16 bits: saturation event counter.

Function
REQ-012 SHALL implement FSM states IDLE=0, RAMP_UP=1, RUN=2, RAMP_DN=3.
REQ-013 SHALL, with ramp register r (0..2^RAMP_BITS), use these transitions:
- IDLE: r=0; enable=1 -> RAMP_UP.
- RAMP_UP: r+1 per clock; at r=2^RAMP_BITS -> RUN; enable=0 -> RAMP_DN, keeping current r.
- RUN: r=2^RAMP_BITS; enable=0 -> RAMP_DN.
- RAMP_DN: r-1 per clock; at r=0 -> IDLE; enable=1 -> RAMP_UP, keeping current r.
REQ-014 SHALL run datapath stage 1 (registered) as s1 = in_sample <<< gain_shift, saturated to [-2^(BIT_DAC-1), 2^(BIT_DAC-1)-1], with flag sat1 set when clipped.
REQ-015 SHALL run datapath stage 2 (registered) as s2 = (s1 * r) >>> RAMP_BITS, arithmetic shift with floor rounding, using the r value current when s1 is consumed; the full-width product SHALL NOT overflow.
REQ-016 SHALL output dac_data = fmt(s2), giving a latency of exactly 2 clocks from in_sample to dac_data.
REQ-017 SHALL drive dac_valid as (state != IDLE) delayed 2 clocks, aligned with dac_data.
REQ-018 SHALL force dac_data to the mid-scale code whenever the aligned dac_valid is 0.
REQ-019 SHALL increment sat_count on each clock where sat1=1 and the aligned state is RUN; sat_count SHALL hold at 16'hFFFF.
REQ-020 SHALL treat a gain_shift change as effective on the next sample, with no glitch handling.

Reset
REQ-021 SHALL, while reset=0, asynchronously force state=IDLE, r=0, s1=s2=0, sat1=0, dac_valid=0, sat_count=0, and dac_data=mid-scale.
REQ-022 SHALL, on reset mid-ramp or mid-RUN, abandon the ramp with no ramp-down; the output goes to mid-scale immediately.

Configuration
REQ-023 SHALL, with macro DAC_OFFSET_BIN_EN defined, produce dac_data as offset binary (MSB of s2 inverted) with mid-scale 14'h2000.
REQ-024 SHALL, with DAC_OFFSET_BIN_EN undefined, produce dac_data as two's complement s2 with mid-scale 14'h0000.

Verification (DAC_OFFSET_BIN_EN defined unless noted)
REQ-025 SHALL cover reset: reset=0 -> dac_data=14'h2000, dac_valid=0, state=0, sat_count=0.
REQ-026 SHALL cover ramp-up: enable=1, in_sample=1000, gain_shift=0 -> state 1, s2 = floor(1000*k/16) = 62, 125, 187, ... ; RUN after 16 clocks; dac_data=9192 (1000+8192).
REQ-027 SHALL cover negative floor rounding: in_sample=-1000, r=1 -> s2=-63 (dac_data=8129).
REQ-028 SHALL cover saturation in RUN: gain_shift=2, in_sample=3000 -> s2=8191 (dac_data=14'h3FFF) and sat_count +1 per clock; in_sample=-3000 -> s2=-8192 (dac_data=0).
REQ-029 SHALL cover ramp reversal: enable=0 at r=5 -> r = 4, 3, 2; enable=1 at r=2 -> r = 3, 4, ...; drop enable in RUN -> 16 clocks to IDLE, dac_valid=0, dac_data=14'h2000.
REQ-030 SHALL cover build without DAC_OFFSET_BIN_EN: idle dac_data=14'h0000; RUN with in_sample=-1 -> dac_data=14'h3FFF.

Source files
------------

// File: rtl/dac_out_ctrl.sv
// dac_out_ctrl: ramped DAC output controller for the 16-QAM transmit IF path.
// Stage 1 applies a 0..3 bit left-shift gain with saturation. Stage 2 scales
// the sample by a ramp value r in 0..2^RAMP_BITS so the carrier fades in and
// out. Saturation events in RUN are counted.
// Build option: define DAC_OFFSET_BIN_EN for offset-binary DAC codes
// (mid-scale 1000..0); otherwise the code is two's complement (mid-scale 0).
//
//   state     | meaning
//   ----------+------------------------------------------------
//   IDLE      | output parked at mid-scale, r held at 0
//   RAMP_UP   | r counts up one per clock toward full scale
//   RUN       | r at 2^RAMP_BITS, full-amplitude output
//   RAMP_DN   | r counts down one per clock toward IDLE

module dac_out_ctrl #(
    parameter int BIT_DAC   = 14,
    parameter int RAMP_BITS = 4
) (
    input  logic               clock_5000,
    input  logic               reset,
    input  logic               enable,
    input  logic [BIT_DAC-1:0] in_sample,
    input  logic [1:0]         gain_shift,
    output logic [BIT_DAC-1:0] dac_data,
    output logic               dac_valid,
    output logic [1:0]         state,
    output logic [15:0]        sat_count
);

    localparam int RW  = RAMP_BITS + 1;
    localparam int EXT = BIT_DAC + 3;
    localparam int PW  = BIT_DAC + RW + 1;

    localparam logic [RW-1:0] RAMP_MAX = RW'(1 << RAMP_BITS);
    localparam logic signed [EXT-1:0] SAT_POS = {4'b0000, {(BIT_DAC-1){1'b1}}};
    localparam logic signed [EXT-1:0] SAT_NEG = {4'b1111, {(BIT_DAC-1){1'b0}}};

`ifdef DAC_OFFSET_BIN_EN
    localparam logic [BIT_DAC-1:0] MID = {1'b1, {(BIT_DAC-1){1'b0}}};
`else
    localparam logic [BIT_DAC-1:0] MID = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RAMP_UP = 2'd1,
        S_RUN     = 2'd2,
        S_RAMP_DN = 2'd3
    } state_t;

    state_t                     r_state;
    logic [RW-1:0]              r_ramp;
    logic signed [BIT_DAC-1:0]  r_s1;
    logic                       r_sat1;
    logic                       r_run_d1;
    logic                       r_valid_d1;
    logic                       r_dac_valid;
    logic [BIT_DAC-1:0]         r_dac_data;
    logic [15:0]                r_sat_count;

    logic signed [EXT-1:0]      w_ext;
    logic signed [EXT-1:0]      w_shift;
    logic signed [BIT_DAC-1:0]  w_s1_next;
    logic                       w_sat_next;
    logic signed [PW-1:0]       w_s1_x;
    logic signed [PW-1:0]       w_r_x;
    logic signed [PW-1:0]       w_prod;
    logic signed [BIT_DAC-1:0]  w_s2_next;
    logic [BIT_DAC-1:0]         w_code;

    // Ramp sequencer: direction reversals keep the current r so the envelope stays continuous
    always_ff @(posedge clock_5000 or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ramp  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ramp <= '0;
                    if (enable) r_state <= S_RAMP_UP;
                end
                S_RAMP_UP: begin
                    if (!enable) begin
                        r_state <= S_RAMP_DN;
                    end else begin
                        r_ramp <= r_ramp + RW'(1);
                        if (r_ramp == RAMP_MAX - RW'(1)) r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_ramp <= RAMP_MAX;
                    if (!enable) r_state <= S_RAMP_DN;
                end
                S_RAMP_DN: begin
                    if (enable) begin
                        r_state <= S_RAMP_UP;
                    end else if (r_ramp <= RW'(1)) begin
                        r_ramp  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_ramp <= r_ramp - RW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gain shift with clipping; three guard bits hold the largest shifted value
    always_comb begin
        w_ext      = {{3{in_sample[BIT_DAC-1]}}, in_sample};
        w_shift    = w_ext <<< gain_shift;
        w_sat_next = 1'b0;
        w_s1_next  = BIT_DAC'(w_shift);
        if (w_shift > SAT_POS) begin
            w_s1_next  = {1'b0, {(BIT_DAC-1){1'b1}}};
            w_sat_next = 1'b1;
        end else if (w_shift < SAT_NEG) begin
            w_s1_next  = {1'b1, {(BIT_DAC-1){1'b0}}};
            w_sat_next = 1'b1;
        end
    end

    // Ramp scaling; product is wide enough for full-scale s1 times 2^RAMP_BITS
    always_comb begin
        w_s1_x    = {{(PW-BIT_DAC){r_s1[BIT_DAC-1]}}, r_s1};
        w_r_x     = {{(PW-RW){1'b0}}, r_ramp};
        w_prod    = w_s1_x * w_r_x;
        w_s2_next = BIT_DAC'(w_prod >>> RAMP_BITS);
`ifdef DAC_OFFSET_BIN_EN
        w_code    = w_s2_next ^ MID;
`else
        w_code    = w_s2_next;
`endif
    end

    // Two-stage datapath with the validity flag carried alongside
    always_ff @(posedge clock_5000 or negedge reset) begin
        if (!reset) begin
            r_s1        <= '0;
            r_sat1      <= 1'b0;
            r_run_d1    <= 1'b0;
            r_valid_d1  <= 1'b0;
            r_dac_valid <= 1'b0;
            r_dac_data  <= MID;
        end else begin
            r_s1        <= w_s1_next;
            r_sat1      <= w_sat_next;
            r_run_d1    <= (r_state == S_RUN);
            r_valid_d1  <= (r_state != S_IDLE);
            r_dac_valid <= r_valid_d1;
            r_dac_data  <= r_valid_d1 ? w_code : MID;
        end
    end

    // Count clipped samples taken while running; sticks at all-ones
    always_ff @(posedge clock_5000 or negedge reset) begin
        if (!reset) begin
            r_sat_count <= '0;
        end else if (r_sat1 && r_run_d1 && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign dac_data  = r_dac_data;
    assign dac_valid = r_dac_valid;
    assign state     = r_state;
    assign sat_count = r_sat_count;

endmodule
